// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator sequencer and its adder.
package calc_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StMul  = 2'b10,
        StDone = 2'b11
    } state_t;

endpackage

// File: rtl/adder8.sv
// 8-bit ripple-carry adder/subtractor; cin=1 inverts b and adds one (a - b).
module adder8
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              overflow
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   carry;

    assign b_eff = b ^ {DATA_W{cin}};

    always_comb begin
        carry[0] = cin;
        sum      = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_eff[i]) | (a[i] & carry[i]) | (b_eff[i] & carry[i]);
        end
        // Signed overflow: carry into the sign bit differs from carry out of it.
        overflow = carry[DATA_W-1] ^ carry[DATA_W];
    end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle ADD/SUB/MUL controller around one shared adder8.
// MUL support is compiled in only when CALC_SEQUENCER_MUL_EN is defined.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              err
);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] add_a, add_b, add_sum;
    logic              add_cin, add_ov;

`ifdef CALC_SEQUENCER_MUL_EN
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
`endif

    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_cin = (op_q == OP_SUB);
`ifdef CALC_SEQUENCER_MUL_EN
        // Negative multiplier: subtract a each pass so the loop count stays |b|.
        if (state_q == StMul) begin
            add_a   = acc_q;
            add_b   = a_q;
            add_cin = neg_q;
        end
`endif
    end

    adder8 u_adder8 (
        .a        (add_a),
        .b        (add_b),
        .cin      (add_cin),
        .sum      (add_sum),
        .overflow (add_ov)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;
`ifdef CALC_SEQUENCER_MUL_EN
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d       = op;
                    a_d        = a;
                    b_d        = b;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
`ifdef CALC_SEQUENCER_MUL_EN
                    acc_d      = '0;
                    cnt_d      = b[DATA_W-1] ? (~b + 1'b1) : b;
                    neg_d      = b[DATA_W-1];
                    state_d    = (op == OP_MUL) ? StMul : StExec;
`else
                    state_d    = StExec;
`endif
                end
            end
            StExec: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    result_d   = add_sum;
                    overflow_d = add_ov;
                end else begin
                    result_d   = '0;
                    overflow_d = 1'b0;
                    err_d      = 1'b1;
                end
                state_d = StDone;
            end
`ifdef CALC_SEQUENCER_MUL_EN
            StMul: begin
                if (cnt_q != '0) begin
                    acc_d      = add_sum;
                    overflow_d = overflow_q | add_ov;
                    cnt_d      = cnt_q - 1'b1;
                end else begin
                    result_d = acc_q;
                    state_d  = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef CALC_SEQUENCER_MUL_EN
            cnt_q      <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
`ifdef CALC_SEQUENCER_MUL_EN
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
`endif
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed and random operations against
// an arithmetic reference model (integer sums/products, range checks, |b| latency).
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       overflow;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference: true integer arithmetic, then range check and truncation.
    function automatic void model(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                                  output logic [7:0] r, output logic ov, output logic er,
                                  output int lat);
        int sa = $signed(aa);
        int sb = $signed(bb);
        int v  = 0;
        r   = 8'h00;
        ov  = 1'b0;
        er  = 1'b0;
        lat = 2;
        case (o)
            2'b00: v = sa + sb;
            2'b01: v = sa - sb;
            2'b10: begin
`ifdef CALC_SEQUENCER_MUL_EN
                v   = sa * sb;
                lat = 2 + ((sb < 0) ? -sb : sb);
`else
                er  = 1'b1;
`endif
            end
            default: er = 1'b1;
        endcase
        if (!er) begin
            r  = v[7:0];
            ov = (v > 127) || (v < -128);
        end
    endfunction

    // Issue one operation from a negedge; returns at the negedge of the idle cycle
    // after done, so a following call is accepted at the minimum interval.
    task automatic run_op(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input bit pulse, output logic [7:0] r, output logic ov,
                          output logic er, output int dcyc, output int ndone,
                          output logic busy1);
        op    = o;
        a     = aa;
        b     = bb;
        start = 1'b1;
        dcyc  = -1;
        ndone = 0;
        r     = 'x;
        ov    = 'x;
        er    = 'x;
        busy1 = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) busy1 = busy;
            if (done) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = cyc;
                    r    = result;
                    ov   = overflow;
                    er   = err;
                end
            end
            if (dcyc >= 0 && cyc == dcyc + 1) break;
            start = pulse & busy;
            if (pulse) begin
                op = 2'($urandom);
                a  = 8'($urandom);
                b  = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, result, overflow, err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h ov=%b err=%b want all 0",
                     busy, done, result, overflow, err);
        end
    endtask

    // Runs one op through the DUT and compares every observable against the model.
    task automatic test_one(input string name, input logic [1:0] o, input logic [7:0] aa,
                            input logic [7:0] bb, input bit pulse);
        logic [7:0] r, er_r;
        logic       ov, er, er_ov, er_er, b1;
        int         dc, nd, lat;
        model(o, aa, bb, er_r, er_ov, er_er, lat);
        run_op(o, aa, bb, pulse, r, ov, er, dc, nd, b1);
        n_checks++;
        if ({r, ov, er} !== {er_r, er_ov, er_er}) begin
            n_fail++;
            $display("FAIL %s_value op=%0d a=%0d b=%0d: got result=%h ov=%b err=%b want %h %b %b",
                     name, o, $signed(aa), $signed(bb), r, ov, er, er_r, er_ov, er_er);
        end
        n_checks++;
        if (dc !== lat || nd !== 1 || b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timing op=%0d a=%0d b=%0d: got done_cycle=%0d dones=%0d busy=%b want %0d 1 1",
                     name, o, $signed(aa), $signed(bb), dc, nd, b1, lat);
        end
    endtask

    task automatic test_add_sub();
        test_one("add_127", 2'b00, 8'd100, 8'd27, 1'b0);
        test_one("add_ovf", 2'b00, 8'd100, 8'd28, 1'b0);
        test_one("sub_ovf", 2'b01, 8'h80, 8'd1, 1'b0);
        test_one("sub_neg", 2'b01, 8'd5, 8'd7, 1'b0);
        test_one("sub_min", 2'b01, 8'd0, 8'h80, 1'b0);
        for (int i = 0; i < 12; i++)
            test_one("addsub_rand", 2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic test_mul();
        test_one("mul_neg", 2'b10, 8'd12, 8'hF6, 1'b0);
        test_one("mul_min_ovf", 2'b10, 8'h80, 8'hFF, 1'b0);
        test_one("mul_zero", 2'b10, 8'd37, 8'd0, 1'b0);
        test_one("mul_b_min", 2'b10, 8'd1, 8'h80, 1'b0);
        test_one("mul_b_min_ovf", 2'b10, 8'hFF, 8'h80, 1'b0);
        for (int i = 0; i < 12; i++)
            test_one("mul_rand", 2'b10, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic test_reserved();
        test_one("rsv", 2'b11, 8'($urandom), 8'($urandom), 1'b0);
        test_one("rsv_zero", 2'b11, 8'd0, 8'd0, 1'b0);
        test_one("op10", 2'b10, 8'd7, 8'd3, 1'b0);
    endtask

    task automatic test_busy_ignore();
        test_one("busy_mul0", 2'b10, 8'd37, 8'd0, 1'b1);
        test_one("busy_add", 2'b00, 8'd45, 8'hD0, 1'b1);
        test_one("busy_mul", 2'b10, 8'hFB, 8'd9, 1'b1);
        test_one("busy_rsv", 2'b11, 8'd1, 8'd2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            test_one("b2b", 2'($urandom), 8'($urandom), 8'($urandom_range(0, 40)), 1'b0);
    endtask

    task automatic test_rst_abort();
        logic [7:0] er_r;
        logic       er_ov, er_er;
        int         lat, nd_before, nd_after;
        model(2'b10, 8'd3, 8'd50, er_r, er_ov, er_er, lat);
        op        = 2'b10;
        a         = 8'd3;
        b         = 8'd50;
        start     = 1'b1;
        nd_before = 0;
        nd_after  = 0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd_before++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (nd_before !== ((lat < 20) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL abort_pre_done: got %0d dones before reset want %0d",
                     nd_before, (lat < 20) ? 1 : 0);
        end
        n_checks++;
        if ({busy, done, result, overflow, err} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h ov=%b err=%b want all 0",
                     busy, done, result, overflow, err);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) nd_after++;
        end
        n_checks++;
        if (nd_after !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d dones after reset want 0", nd_after);
        end
        test_one("after_abort_add", 2'b00, 8'd1, 8'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_reserved();
        test_busy_ignore();
        test_back_to_back();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
